// File: rtl/sargantana_icache_pkg.sv
// Shared I-cache types: refill FSM states, line/beat geometry and the
// ifill request/response structs used between the I-cache and its refill unit.
package sargantana_icache_pkg;

    localparam int PADDR_WIDTH = 40;
    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 128;
    localparam int N_WAY       = 4;
    localparam int WAY_W       = $clog2(N_WAY);
    localparam int N_BEATS     = LINE_WIDTH / BEAT_WIDTH;
    // Keep the counter at least one bit wide even for a single-beat line.
    localparam int BEAT_CNT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BEATS,
        RESP,
        DRAIN
    } refill_state_t;

    typedef struct packed {
        logic                   valid;
        logic [PADDR_WIDTH-1:0] paddr;
        logic [WAY_W-1:0]       way;
    } ifill_req_t;

    typedef struct packed {
        logic                  valid;
        logic [LINE_WIDTH-1:0] data;
        logic [WAY_W-1:0]      way;
    } ifill_resp_t;

    typedef struct packed {
        refill_state_t         state;
        logic [BEAT_CNT_W-1:0] beat_cnt;
    } refill_dbg_t;

endpackage

// File: rtl/sargantana_icache_refill_unit.sv
// I-cache miss refill engine: one L2 read per ifill request, beats assembled
// into a full line and returned as a one-cycle response; kills drain the L2 read.
module sargantana_icache_refill_unit
    import sargantana_icache_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    input  logic [PADDR_WIDTH-1:0] req_paddr_i,
    input  logic [WAY_W-1:0]       req_way_i,
    input  logic                   kill_i,
    output logic                   req_ready_o,
    output logic                   resp_valid_o,
    output logic [LINE_WIDTH-1:0]  resp_data_o,
    output logic [WAY_W-1:0]       resp_way_o,
    output logic                   busy_o,
    output logic                   l2_req_valid_o,
    output logic [PADDR_WIDTH-1:0] l2_req_paddr_o,
    input  logic                   l2_req_ready_i,
    input  logic                   l2_beat_valid_i,
    input  logic [BEAT_WIDTH-1:0]  l2_beat_data_i,
    output refill_dbg_t            dbg_o
);

    // Handshakes: a request transfers on a cycle where valid and ready are both
    // high; valid never depends on ready, and an L2 beat transfers whenever its valid is high.

    refill_state_t          state_q, state_d;
    logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [PADDR_WIDTH-1:0] paddr_q;
    logic [WAY_W-1:0]       way_q;
    logic [LINE_WIDTH-1:0]  line_q;
    logic                   latch_req;
    logic                   write_beat;
    logic                   last_beat;
    logic [BEAT_CNT_W-1:0]  beat_cnt_inc;

    assign last_beat    = (beat_cnt_q == BEAT_CNT_W'(N_BEATS - 1));
    assign beat_cnt_inc = last_beat ? '0 : beat_cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        latch_req      = 1'b0;
        write_beat     = 1'b0;
        req_ready_o    = 1'b0;
        resp_valid_o   = 1'b0;
        l2_req_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && !kill_i) begin
                    latch_req = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                l2_req_valid_o = 1'b1;
                // Once the L2 has accepted the read its beats must be consumed.
                if (l2_req_ready_i) begin
                    beat_cnt_d = '0;
                    state_d    = kill_i ? DRAIN : BEATS;
                end else if (kill_i) begin
                    state_d = IDLE;
                end
            end
            BEATS: begin
                if (l2_beat_valid_i) begin
                    write_beat = !kill_i;
                    beat_cnt_d = beat_cnt_inc;
                    if (last_beat) begin
                        state_d = kill_i ? IDLE : RESP;
                    end else if (kill_i) begin
                        state_d = DRAIN;
                    end
                end else if (kill_i) begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                resp_valid_o = !kill_i;
                state_d      = IDLE;
            end
            DRAIN: begin
                if (l2_beat_valid_i) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            paddr_q    <= '0;
            way_q      <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            if (latch_req) begin
                paddr_q <= req_paddr_i;
                way_q   <= req_way_i;
            end
            if (write_beat) begin
                for (int i = 0; i < N_BEATS; i++) begin
                    if (beat_cnt_q == BEAT_CNT_W'(i)) begin
                        line_q[i*BEAT_WIDTH +: BEAT_WIDTH] <= l2_beat_data_i;
                    end
                end
            end
        end
    end

    assign resp_data_o    = line_q;
    assign resp_way_o     = way_q;
    assign l2_req_paddr_o = paddr_q;
    assign busy_o         = (state_q != IDLE);
    assign dbg_o.state    = state_q;
    assign dbg_o.beat_cnt = beat_cnt_q;

    // A beat with no accepted L2 read outstanding means the L2 side is broken.
    no_beat_without_read: assert property (@(posedge clk_i) disable iff (rst_i)
        !(l2_beat_valid_i && (state_q == IDLE || state_q == REQ)));

endmodule
